// File: rtl/riscv_pkg.sv
// Shared types for the integer writeback path.
//   XLEN / REG_ADDR_W : datapath and register-address widths
//   wb_entry_t        : one pending register-file write {rd, value}
//   wb_grant_e        : which producer owns the write port this cycle
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     value;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } wb_grant_e;

endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// Bus bundle between the producers / issue stage and the writeback arbiter.
//   alu_* / lsu_* : valid/ready result channels from the two producers
//   wr/rd0/rd0_*  : register-file write port
//   ra0/rb0       : issue-stage operand queries and their busy answers
//   idle_o        : nothing pending anywhere in the writeback path
// Modports: slave = arbiter side, master = environment side.
interface riscv_wb_arbiter_if;
  import riscv_pkg::*;

  logic      alu_valid_i;
  logic      alu_ready_o;
  reg_addr_t alu_rd_i;
  xlen_t     alu_value_i;

  logic      lsu_valid_i;
  logic      lsu_ready_o;
  reg_addr_t lsu_rd_i;
  xlen_t     lsu_value_i;

  logic      wr_o;
  reg_addr_t rd0_o;
  xlen_t     rd0_value_o;

  reg_addr_t ra0_i;
  reg_addr_t rb0_i;
  logic      ra0_busy_o;
  logic      rb0_busy_o;

  logic      idle_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_value_i,
    input  lsu_valid_i, lsu_rd_i, lsu_value_i,
    input  ra0_i, rb0_i,
    output alu_ready_o, lsu_ready_o,
    output wr_o, rd0_o, rd0_value_o,
    output ra0_busy_o, rb0_busy_o, idle_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_value_i,
    output lsu_valid_i, lsu_rd_i, lsu_value_i,
    output ra0_i, rb0_i,
    input  alu_ready_o, lsu_ready_o,
    input  wr_o, rd0_o, rd0_value_o,
    input  ra0_busy_o, rb0_busy_o, idle_o
  );

endinterface

// File: rtl/riscv_wb_fifo.sv
// Per-producer writeback FIFO.
//   clk_i, rstn_i      : clock, asynchronous active-low reset
//   push_i/push_entry_i: enqueue an entry (ignored when full)
//   pop_i              : dequeue the head entry (ignored when empty)
//   qa_i/qb_i          : register addresses to look up among valid entries
//   head_o             : oldest entry
//   empty_o, count_o   : occupancy
//   ready_o            : can accept, from the registered count only
//   qa_match_o/qb_match_o : some valid entry targets qa_i / qb_i
module riscv_wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  reg_addr_t        qa_i,
  input  reg_addr_t        qb_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ready_o,
  output logic             qa_match_o,
  output logic             qb_match_o
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;
  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;

  assign ready_o = count_q < CNT_W'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign do_push = push_i && ready_o;
  assign do_pop  = pop_i && !empty_o;

  // Payload storage carries no reset: occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer (modulo the
  // power-of-two depth) is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] offset;
    logic             live;
    assign offset    = PTR_W'(gi) - rd_ptr_q;
    assign live      = {1'b0, offset} < count_q;
    assign hit_a[gi] = live && (mem[gi].rd == qa_i);
    assign hit_b[gi] = live && (mem[gi].rd == qb_i);
  end

  assign qa_match_o = |hit_a;
  assign qb_match_o = |hit_b;

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file
// write port with fixed ALU priority and an LSU starvation guard, and answers
// issue-stage "write pending?" queries.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus           : riscv_wb_arbiter_if.slave (producer channels, write port,
//                   operand busy queries, idle)
// Parameters: DEPTH entries per producer FIFO (power of two, >= 2),
//             STARVE_LIMIT lost arbitrations before the LSU is forced (1..15).
module riscv_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  riscv_wb_arbiter_if.slave     bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        alu_head,     lsu_head;
  logic             alu_empty,    lsu_empty;
  logic [CNT_W-1:0] alu_count,    lsu_count;
  logic             alu_ready,    lsu_ready;
  logic             alu_qa_match, lsu_qa_match;
  logic             alu_qb_match, lsu_qb_match;
  logic             alu_push,     lsu_push;

  wb_grant_e        gnt;
  logic [3:0]       lsu_wait_q;
  logic             wr_q;
  wb_entry_t        out_q;

  // Writes to x0 are accepted on the handshake but never enqueued.
  assign alu_push = bus.alu_valid_i && alu_ready && (bus.alu_rd_i != '0);
  assign lsu_push = bus.lsu_valid_i && lsu_ready && (bus.lsu_rd_i != '0);

  riscv_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .push_i       (alu_push),
    .push_entry_i ('{rd: bus.alu_rd_i, value: bus.alu_value_i}),
    .pop_i        (gnt == GNT_ALU),
    .qa_i         (bus.ra0_i),
    .qb_i         (bus.rb0_i),
    .head_o       (alu_head),
    .empty_o      (alu_empty),
    .count_o      (alu_count),
    .ready_o      (alu_ready),
    .qa_match_o   (alu_qa_match),
    .qb_match_o   (alu_qb_match)
  );

  riscv_wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .push_i       (lsu_push),
    .push_entry_i ('{rd: bus.lsu_rd_i, value: bus.lsu_value_i}),
    .pop_i        (gnt == GNT_LSU),
    .qa_i         (bus.ra0_i),
    .qb_i         (bus.rb0_i),
    .head_o       (lsu_head),
    .empty_o      (lsu_empty),
    .count_o      (lsu_count),
    .ready_o      (lsu_ready),
    .qa_match_o   (lsu_qa_match),
    .qb_match_o   (lsu_qb_match)
  );

  assign bus.alu_ready_o = alu_ready;
  assign bus.lsu_ready_o = lsu_ready;

  // ALU wins by default; the LSU takes the port when the ALU has nothing or
  // when it has already lost STARVE_LIMIT consecutive arbitrations.
  always_comb begin
    gnt = GNT_NONE;
    if (!lsu_empty && (alu_empty || lsu_wait_q >= 4'(STARVE_LIMIT))) begin
      gnt = GNT_LSU;
    end else if (!alu_empty) begin
      gnt = GNT_ALU;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q       <= 1'b0;
      out_q      <= '0;
      lsu_wait_q <= '0;
    end else begin
      wr_q <= (gnt != GNT_NONE);
      // Address/data hold their last value when nothing is granted.
      case (gnt)
        GNT_ALU: out_q <= alu_head;
        GNT_LSU: out_q <= lsu_head;
        default: out_q <= out_q;
      endcase
      if (lsu_empty || gnt == GNT_LSU) begin
        lsu_wait_q <= '0;
      end else if (gnt == GNT_ALU && lsu_wait_q != 4'hF) begin
        lsu_wait_q <= lsu_wait_q + 4'd1;
      end
    end
  end

  assign bus.wr_o        = wr_q;
  assign bus.rd0_o       = out_q.rd;
  assign bus.rd0_value_o = out_q.value;

  // A register stays busy while it sits in either FIFO or is being written
  // this cycle; x0 is never busy.
  assign bus.ra0_busy_o = (bus.ra0_i != '0) &&
                          (alu_qa_match || lsu_qa_match || (wr_q && out_q.rd == bus.ra0_i));
  assign bus.rb0_busy_o = (bus.rb0_i != '0) &&
                          (alu_qb_match || lsu_qb_match || (wr_q && out_q.rd == bus.rb0_i));

  assign bus.idle_o = (alu_count == '0) && (lsu_count == '0) && !wr_q;

endmodule

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
- Write-side master for the integer register file.
- Merges writeback results from two producers into the single register-file write port (wr / rd0 / rd0_value):
  - ALU: single-cycle results.
  - LSU: load and multi-cycle results.
- Each producer has a small FIFO. Arbitration is fixed-priority with a starvation guard.
- A combinational scoreboard tells the issue stage whether a source operand still has a write pending.

Parameters:
- DEPTH, 2: entries per producer FIFO; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles the LSU can lose arbitration before it is forced a grant; 1..15.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU FIFO can accept.
- alu_rd_i  in  5  ALU destination register.
- alu_value_i  in  32  ALU result.
- lsu_valid_i  in  1  LSU result valid.
- lsu_ready_o  out  1  LSU FIFO can accept.
- lsu_rd_i  in  5  LSU destination register.
- lsu_value_i  in  32  LSU result.
- wr_o  out  1  register-file write enable.
- rd0_o  out  5  register-file write address.
- rd0_value_o  out  32  register-file write data.
- ra0_i  in  5  issue-stage source-A query address.
- rb0_i  in  5  issue-stage source-B query address.
- ra0_busy_o  out  1  write to ra0_i still pending.
- rb0_busy_o  out  1  write to rb0_i still pending.
- idle_o  out  1  both FIFOs empty and wr_o low.

Behaviour:
- Reset, asynchronous:
  - FIFOs empty, lsu_wait_q = 0.
  - wr_o = 0, rd0_o = 0, rd0_value_o = 0.
  - ready outputs = 1 and idle_o = 1 after reset.
  - Entries pending when reset asserts are discarded. No write issues after release.
- Handshake:
  - Transfer occurs when valid & ready at a rising edge.
  - x_ready_o = (count < DEPTH), using the registered count only. No same-cycle pop-through.
  - valid may not depend on ready.
- x0 filtering: a transfer with rd = 0 is accepted and dropped. It is not pushed, is never written, and never sets busy.
- Latency:
  - Entry pushed at edge t into an empty FIFO, with its source granted, appears on wr_o/rd0_o/rd0_value_o in the cycle after edge t+1.
  - wr_o is high for exactly one cycle per entry.
  - Output registers load on every edge: wr_o = 1 with the popped entry if a grant occurs, else wr_o = 0. rd0_o and rd0_value_o hold their old values when no grant occurs.
- Arbitration, one pop per cycle at most:
  - Grant LSU if the LSU FIFO is non-empty and (ALU FIFO empty or lsu_wait_q ≥ STARVE_LIMIT).
  - Otherwise grant ALU if its FIFO is non-empty.
- lsu_wait_q (4-bit, saturating):
  - Increments when the LSU FIFO is non-empty and ALU is granted.
  - Clears when LSU is granted or the LSU FIFO is empty.
- Ordering:
  - FIFO order is preserved within a source.
  - No ordering is enforced across sources. The issue stage prevents WAW between sources by stalling on busy.
- Scoreboard (combinational):
  - ra0_busy_o = (ra0_i ≠ 0) & (ra0_i matches any valid entry of either FIFO, or (wr_o & rd0_o == ra0_i)).
  - rb0_busy_o uses the same rule with rb0_i.
  - Busy falls in the cycle after the final wr_o for that register.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- A full FIFO with valid high holds ready low. No entry is lost or overwritten.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN = 32 and REG_ADDR_W = 5.
  - A writeback-entry struct {rd, value}.
- One sub-module, riscv_wb_fifo, parameterised by DEPTH and instantiated twice:
  - Outputs: head entry, empty, count, ready.
  - Also outputs a per-query match bit for ra0_i and rb0_i, computed over its valid entries.
- The top level holds the arbiter, lsu_wait_q, output registers and the busy OR-reduction.

Test Plan:
- Single ALU write: rd = 5, value 0xDEADBEEF at edge t → wr_o = 1, rd0_o = 5, rd0_value_o = 0xDEADBEEF for exactly the cycle after edge t+1; idle_o returns to 1 one cycle later.
- x0 drop: ALU rd = 0, value 0x12345678 → accepted with alu_ready_o = 1; wr_o never asserts; busy for ra0_i = 0 stays 0; idle_o stays 1.
- Starvation: both sources valid every cycle, distinct rds, STARVE_LIMIT = 4 → grant sequence of 4 ALU, 1 LSU, repeating; every value is written once and in per-source order.
- Backpressure: LSU sends 3 back-to-back while ALU streams continuously → lsu_ready_o drops after the 2nd accept; the 3rd transfer completes the cycle after the first LSU pop; no data lost.
- Scoreboard: LSU pending rd = 10, ra0_i = 10, rb0_i = 0 → ra0_busy_o = 1 and rb0_busy_o = 0 until the cycle after wr_o with rd0_o = 10, then ra0_busy_o = 0.
- Reset mid-operation: 3 entries pending, rstn_i low mid-cycle → wr_o, rd0_o, rd0_value_o go to 0 immediately; after release no wr_o pulses, idle_o = 1, both ready outputs = 1.
